// File: rtl/rect_renderer.sv
// rect_renderer: one-stage streaming pixel shader.
// A pixel that falls inside a fixed axis-aligned rectangle takes the fill colour.
// Every other pixel keeps its input colour.
// Coordinates pass through with one cycle of latency, so several instances can be chained.
// Optional macro RECT_OUTLINE_EN: fill only the 1-pixel border of the rectangle.
module rect_renderer #(
  parameter int         x_coord = 0,
  parameter int         y_coord = 0,
  parameter int         width   = 32,
  parameter int         height  = 32,
  parameter logic [7:0] fill_r  = 8'hFF,
  parameter logic [7:0] fill_g  = 8'hFF,
  parameter logic [7:0] fill_b  = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [10:0] x,
  input  logic signed [11:0] y,
  input  logic        [7:0]  r,
  input  logic        [7:0]  g,
  input  logic        [7:0]  b,
  output logic signed [10:0] x_out,
  output logic signed [11:0] y_out,
  output logic        [7:0]  r_out,
  output logic        [7:0]  g_out,
  output logic        [7:0]  b_out
);

  // Bounds are held in 14-bit signed, so extreme coordinates can never wrap into the box.
  localparam logic signed [13:0] X_LO   = 14'(x_coord);
  localparam logic signed [13:0] X_HI   = 14'(x_coord + width);
  localparam logic signed [13:0] Y_LO   = 14'(y_coord);
  localparam logic signed [13:0] Y_HI   = 14'(y_coord + height);
`ifdef RECT_OUTLINE_EN
  localparam logic signed [13:0] X_LAST = 14'(x_coord + width - 1);
  localparam logic signed [13:0] Y_LAST = 14'(y_coord + height - 1);
`endif

  logic signed [13:0] w_x;
  logic signed [13:0] w_y;
  logic               w_inside;
  logic               w_fill;
  logic        [7:0]  w_r;
  logic        [7:0]  w_g;
  logic        [7:0]  w_b;

  assign w_x = {{3{x[10]}}, x};
  assign w_y = {{2{y[11]}}, y};

  // Inside test and colour select on the sampled pixel
  always_comb begin
    w_inside = (w_x >= X_LO) && (w_x < X_HI) && (w_y >= Y_LO) && (w_y < Y_HI);
`ifdef RECT_OUTLINE_EN
    w_fill   = w_inside && ((w_x == X_LO) || (w_x == X_LAST) ||
                            (w_y == Y_LO) || (w_y == Y_LAST));
`else
    w_fill   = w_inside;
`endif
    w_r = r;
    w_g = g;
    w_b = b;
    if (w_fill) begin
      w_r = fill_r;
      w_g = fill_g;
      w_b = fill_b;
    end
  end

  // Output registers: these are the only state; reset clears them and drops the input
  always_ff @(posedge clk) begin
    if (rst) begin
      x_out <= '0;
      y_out <= '0;
      r_out <= '0;
      g_out <= '0;
      b_out <= '0;
    end else begin
      x_out <= x;
      y_out <= y;
      r_out <= w_r;
      g_out <= w_g;
      b_out <= w_b;
    end
  end

endmodule

// File: tb/tb_rect_renderer.sv
// Self-checking bench for rect_renderer.
// Four instances share the same input stream:
//   0: (16,16,16,16), default fill
//   1: (-4,-4,8,8), default fill
//   2: width 0, so the rectangle is empty
//   3: (1020,2040,8,8), fill 11/22/33, at the extreme corner
module tb_rect_renderer;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [10:0] x;
  logic signed [11:0] y;
  logic        [7:0]  r, g, b;

  logic signed [10:0] xo[4];
  logic signed [11:0] yo[4];
  logic        [7:0]  ro[4], go[4], bo[4];

  localparam int         XC[4] = '{16, -4, 0, 1020};
  localparam int         YC[4] = '{16, -4, 0, 2040};
  localparam int         WD[4] = '{16, 8, 0, 8};
  localparam int         HT[4] = '{16, 8, 32, 8};
  localparam logic [7:0] FR[4] = '{8'hFF, 8'hFF, 8'hFF, 8'h11};
  localparam logic [7:0] FG[4] = '{8'hFF, 8'hFF, 8'hFF, 8'h22};
  localparam logic [7:0] FB[4] = '{8'hFF, 8'hFF, 8'hFF, 8'h33};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rect_renderer #(.x_coord(16), .y_coord(16), .width(16), .height(16)) u0 (
    .clk(clk), .rst(rst), .x(x), .y(y), .r(r), .g(g), .b(b),
    .x_out(xo[0]), .y_out(yo[0]), .r_out(ro[0]), .g_out(go[0]), .b_out(bo[0]));
  rect_renderer #(.x_coord(-4), .y_coord(-4), .width(8), .height(8)) u1 (
    .clk(clk), .rst(rst), .x(x), .y(y), .r(r), .g(g), .b(b),
    .x_out(xo[1]), .y_out(yo[1]), .r_out(ro[1]), .g_out(go[1]), .b_out(bo[1]));
  rect_renderer #(.x_coord(0), .y_coord(0), .width(0), .height(32)) u2 (
    .clk(clk), .rst(rst), .x(x), .y(y), .r(r), .g(g), .b(b),
    .x_out(xo[2]), .y_out(yo[2]), .r_out(ro[2]), .g_out(go[2]), .b_out(bo[2]));
  rect_renderer #(.x_coord(1020), .y_coord(2040), .width(8), .height(8),
                  .fill_r(8'h11), .fill_g(8'h22), .fill_b(8'h33)) u3 (
    .clk(clk), .rst(rst), .x(x), .y(y), .r(r), .g(g), .b(b),
    .x_out(xo[3]), .y_out(yo[3]), .r_out(ro[3]), .g_out(go[3]), .b_out(bo[3]));

  // Reference model in plain integer arithmetic: {x, y, r, g, b} expected after one clock
  function automatic logic [46:0] model(input int i, input int sx, input int sy,
                                        input logic [7:0] cr, input logic [7:0] cg,
                                        input logic [7:0] cb);
    bit in_box, paint;
    in_box = (sx >= XC[i]) && (sx < XC[i] + WD[i]) && (sy >= YC[i]) && (sy < YC[i] + HT[i]);
`ifdef RECT_OUTLINE_EN
    paint = in_box && (sx == XC[i] || sx == XC[i] + WD[i] - 1 ||
                       sy == YC[i] || sy == YC[i] + HT[i] - 1);
`else
    paint = in_box;
`endif
    if (paint) return {11'(sx), 12'(sy), FR[i], FG[i], FB[i]};
    else       return {11'(sx), 12'(sy), cr, cg, cb};
  endfunction

  function automatic logic [46:0] dut_out(input int i);
    return {xo[i], yo[i], ro[i], go[i], bo[i]};
  endfunction

  task automatic check(input string name, input logic [46:0] act, input logic [46:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d rgb=%h/%h/%h, want x=%0d y=%0d rgb=%h/%h/%h",
               name, $signed(act[46:36]), $signed(act[35:24]), act[23:16], act[15:8], act[7:0],
               $signed(exp[46:36]), $signed(exp[35:24]), exp[23:16], exp[15:8], exp[7:0]);
    end
  endtask

  // Drive one pixel, then let one clock edge pass before the outputs are sampled
  task automatic apply(input logic rr, input int sx, input int sy,
                       input logic [7:0] cr, input logic [7:0] cg, input logic [7:0] cb);
    rst = rr; x = 11'(sx); y = 12'(sy); r = cr; g = cg; b = cb;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         inst;
    int         sx;
    int         sy;
    logic [7:0] r, g, b;
    logic [7:0] er, eg, eb;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Table of directed edge cases, with hand-derived expected colours
    vecs.push_back('{0, 15, 16, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30});
    vecs.push_back('{0, 16, 16, 8'h10, 8'h20, 8'h30, 8'hFF, 8'hFF, 8'hFF});
    vecs.push_back('{0, 31, 31, 8'h10, 8'h20, 8'h30, 8'hFF, 8'hFF, 8'hFF});
    vecs.push_back('{0, 32, 20, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30});
    vecs.push_back('{0, 20, 32, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30});
    vecs.push_back('{1, -4, -4, 8'h10, 8'h20, 8'h30, 8'hFF, 8'hFF, 8'hFF});
    vecs.push_back('{1, 3, 3, 8'h10, 8'h20, 8'h30, 8'hFF, 8'hFF, 8'hFF});
    vecs.push_back('{1, 4, 0, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30});
    vecs.push_back('{1, -1024, -2048, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30});
    vecs.push_back('{0, 16, 20, 8'h10, 8'h20, 8'h30, 8'hFF, 8'hFF, 8'hFF});
    vecs.push_back('{0, 31, 20, 8'h10, 8'h20, 8'h30, 8'hFF, 8'hFF, 8'hFF});
    vecs.push_back('{0, 20, 16, 8'h10, 8'h20, 8'h30, 8'hFF, 8'hFF, 8'hFF});
`ifdef RECT_OUTLINE_EN
    vecs.push_back('{0, 20, 20, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30});
`else
    vecs.push_back('{0, 20, 20, 8'h10, 8'h20, 8'h30, 8'hFF, 8'hFF, 8'hFF});
`endif
    vecs.push_back('{2, 5, 5, 8'hA5, 8'h5A, 8'h3C, 8'hA5, 8'h5A, 8'h3C});
    vecs.push_back('{3, 1023, 2047, 8'h01, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33});
    vecs.push_back('{3, -1024, -2048, 8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03});
    vecs.push_back('{3, 1019, 2047, 8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03});

    rst = 1'b1; x = '0; y = '0; r = '0; g = '0; b = '0;

    // Reset: outputs stay at zero while rst is held, then the first pixel comes through
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, 5, 5, 8'h12, 8'h12, 8'h12);
      for (int i = 0; i < 4; i++) check($sformatf("reset inst%0d cyc%0d", i, c), dut_out(i), '0);
    end
    apply(1'b0, 5, 5, 8'h12, 8'h12, 8'h12);
    for (int i = 0; i < 4; i++)
      check($sformatf("reset_release inst%0d", i), dut_out(i),
            {11'sd5, 12'sd5, 8'h12, 8'h12, 8'h12});

    // Directed table
    foreach (vecs[k]) begin
      apply(1'b0, vecs[k].sx, vecs[k].sy, vecs[k].r, vecs[k].g, vecs[k].b);
      check($sformatf("vec%0d inst%0d (%0d,%0d)", k, vecs[k].inst, vecs[k].sx, vecs[k].sy),
            dut_out(vecs[k].inst),
            {11'(vecs[k].sx), 12'(vecs[k].sy), vecs[k].er, vecs[k].eg, vecs[k].eb});
    end

    // Raster sweep over 0..31 on black input
    for (int sy = 0; sy < 32; sy++)
      for (int sx = 0; sx < 32; sx++) begin
        apply(1'b0, sx, sy, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++)
          check($sformatf("raster inst%0d (%0d,%0d)", i, sx, sy), dut_out(i),
                model(i, sx, sy, 8'h00, 8'h00, 8'h00));
      end

    // Back-to-back pass-through on the empty rectangle
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, k * 3 - 10, 7 - k * 5, 8'(k * 17), 8'(255 - k), 8'(k << 4));
      check($sformatf("empty b2b %0d", k), dut_out(2),
            {11'(k * 3 - 10), 12'(7 - k * 5), 8'(k * 17), 8'(255 - k), 8'(k << 4)});
    end

    // Random stimulus: full-range coordinates or coordinates near one instance's box,
    // with an occasional reset cycle
    for (int n = 0; n < 3000; n++) begin
      int sx, sy, tgt;
      logic rr;
      logic [7:0] cr, cg, cb;
      tgt = int'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        sx = int'($urandom_range(0, 2047)) - 1024;
        sy = int'($urandom_range(0, 4095)) - 2048;
      end else begin
        sx = XC[tgt] + int'($urandom_range(0, 24)) - 8;
        sy = YC[tgt] + int'($urandom_range(0, 24)) - 8;
        if (sx > 1023) sx = 1023;
        if (sy > 2047) sy = 2047;
      end
      rr = ($urandom_range(0, 49) == 0);
      cr = 8'($urandom); cg = 8'($urandom); cb = 8'($urandom);
      apply(rr, sx, sy, cr, cg, cb);
      for (int i = 0; i < 4; i++)
        check($sformatf("rand%0d inst%0d (%0d,%0d)", n, i, sx, sy), dut_out(i),
              rr ? 47'd0 : model(i, sx, sy, cr, cg, cb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
